// File: rtl/clut_cache_loader_pkg.sv
// -----------------------------------------------------------------------------
// clut_cache_loader_pkg
// Shared definitions for the CLUT cache fill engine:
//   - state_e       : fill FSM states
//   - BURST_LEN     : words per CLUT block fill (16 colours = 8 x 32-bit words)
//   - CLUT_ID field offsets (X in 16-halfword units, Y line)
//   - form_addr()   : VRAM word address of a CLUT block
// -----------------------------------------------------------------------------
package clut_cache_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam int BURST_LEN   = 8;
    localparam int CNT_W       = 3;
    localparam int VRAM_ADDR_W = 18;

    localparam int X_LSB = 0;
    localparam int X_W   = 6;
    localparam int Y_LSB = 6;
    localparam int Y_W   = 9;

    // Block start address: Y line, X (wrapping mod 64 within the same line), word 0.
    function automatic logic [VRAM_ADDR_W-1:0] form_addr(input logic [14:0] clut_id,
                                                         input logic [3:0]  blk);
        logic [X_W-1:0] x_s;
        x_s = clut_id[X_LSB +: X_W] + {2'b00, blk};
        return {clut_id[Y_LSB +: Y_W], x_s, 3'b000};
    endfunction

endpackage

// File: rtl/clut_cache_loader.sv
// -----------------------------------------------------------------------------
// clut_cache_loader
// Fills one 16-colour CLUT block into the CLUT cache after a miss, fetching it
// from VRAM as a single 8-beat burst of 32-bit words.
//
// Ports:
//   clk, i_nrst            clock, asynchronous active-low reset
//   CLUT_ID[15:0]          current CLUT ([5:0] X/16, [14:6] Y line)
//   i_missReq/i_missIdx    miss request (level) and missing colour index
//   o_missAck              1-cycle accept pulse
//   o_busy                 fill (or abort drain) in progress
//   o_fillDone             1-cycle pulse, block completely written
//   o_memReq/o_memAddr     burst request and start word address to arbiter
//   i_memAck               arbiter accepted the burst
//   i_memValid/i_memData   read beats
//   o_write/o_writeIdx/o_colorOut  cache write port
//
// Build option: CLUT_LOADER_PREFETCH_EN -- a CLUT_ID change seen while idle
// with no miss pending starts an internal fill of block 0 (no o_missAck).
// -----------------------------------------------------------------------------
module clut_cache_loader
    import clut_cache_loader_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              i_nrst,
    input  logic [15:0]       CLUT_ID,
    input  logic              i_missReq,
    input  logic [7:0]        i_missIdx,
    output logic              o_missAck,
    output logic              o_busy,
    output logic              o_fillDone,
    output logic              o_memReq,
    output logic [ADDR_W-1:0] o_memAddr,
    input  logic              i_memAck,
    input  logic              i_memValid,
    input  logic [31:0]       i_memData,
    output logic              o_write,
    output logic [6:0]        o_writeIdx,
    output logic [31:0]       o_colorOut
);

    state_e             state_q, state_d;
    logic [3:0]         blk_q, blk_d;
    logic [15:0]        clut_q, clut_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               abort_q, abort_d;

    logic               miss_ack_q, miss_ack_d;
    logic               busy_q, busy_d;
    logic               fill_done_q, fill_done_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               write_q, write_d;
    logic [6:0]         widx_q, widx_d;
    logic [31:0]        color_q, color_d;

    logic               accept_s;
    logic               pf_trig_s;
    logic               clut_diff_s;
    logic               last_beat_s;
    logic               unused_s;

    // Only the block number of the missing index selects the fill.
    assign unused_s    = ^i_missIdx[3:0];
    assign clut_diff_s = (CLUT_ID != clut_q);
    assign last_beat_s = (cnt_q == 3'(BURST_LEN - 1));

`ifdef CLUT_LOADER_PREFETCH_EN
    logic [15:0] last_clut_q;

    // Tracks CLUT_ID every cycle so a change can be detected while idle.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            last_clut_q <= 16'h0000;
        end else begin
            last_clut_q <= CLUT_ID;
        end
    end

    assign pf_trig_s = (CLUT_ID != last_clut_q);
`else
    assign pf_trig_s = 1'b0;
`endif

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= ST_IDLE;
            blk_q       <= 4'd0;
            clut_q      <= 16'h0000;
            cnt_q       <= 3'd0;
            abort_q     <= 1'b0;
            miss_ack_q  <= 1'b0;
            busy_q      <= 1'b0;
            fill_done_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            write_q     <= 1'b0;
            widx_q      <= 7'd0;
            color_q     <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            clut_q      <= clut_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            miss_ack_q  <= miss_ack_d;
            busy_q      <= busy_d;
            fill_done_q <= fill_done_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            write_q     <= write_d;
            widx_q      <= widx_d;
            color_q     <= color_d;
        end
    end

    // Next-state logic; a CLUT_ID change mid-fill diverts to DRAIN so the
    // arbiter burst is always consumed in full.
    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        clut_d   = clut_q;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_missReq) begin
                    accept_s = 1'b1;
                    state_d  = ST_REQ;
                    blk_d    = i_missIdx[7:4];
                    clut_d   = CLUT_ID;
                    cnt_d    = 3'd0;
                    abort_d  = 1'b0;
                end else if (pf_trig_s) begin
                    state_d  = ST_REQ;
                    blk_d    = 4'd0;
                    clut_d   = CLUT_ID;
                    cnt_d    = 3'd0;
                    abort_d  = 1'b0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_REQ: begin
                abort_d = abort_q | clut_diff_s;
                if (i_memAck) begin
                    state_d = (abort_q || clut_diff_s) ? ST_DRAIN : ST_DATA;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DATA: begin
                if (i_memValid) begin
                    cnt_d = cnt_q + 3'd1;
                    if (last_beat_s) begin
                        state_d = clut_diff_s ? ST_IDLE : ST_DONE;
                    end else if (clut_diff_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (clut_diff_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DRAIN: begin
                if (i_memValid) begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = last_beat_s ? ST_IDLE : ST_DRAIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values; every output leaves the block through a register.
    always_comb begin
        miss_ack_d  = accept_s;
        busy_d      = (state_d != ST_IDLE);
        fill_done_d = (state_q == ST_DONE);
        mem_req_d   = (state_d == ST_REQ);
        mem_addr_d  = ADDR_W'(form_addr(clut_d[14:0], blk_d));
        write_d     = (state_q == ST_DATA) && i_memValid && !clut_diff_s;
        if (write_d) begin
            widx_d  = {blk_q, cnt_q};
            color_d = i_memData;
        end else begin
            widx_d  = widx_q;
            color_d = color_q;
        end
    end

    assign o_missAck  = miss_ack_q;
    assign o_busy     = busy_q;
    assign o_fillDone = fill_done_q;
    assign o_memReq   = mem_req_q;
    assign o_memAddr  = mem_addr_q;
    assign o_write    = write_q;
    assign o_writeIdx = widx_q;
    assign o_colorOut = color_q;

endmodule
